// File: rtl/stc0_ingress_arb_if.sv
// Ingress arbiter bus: two frame requesters in, one core ingress stream out.
// master = requester/wrapper side, slave = arbiter side.
interface stc0_ingress_arb_if;
  logic       Req0;
  logic       Req1;
  logic [7:0] D0;
  logic [7:0] D1;
  logic       V0;
  logic       V1;
  logic       L0;
  logic       L1;
  logic       Gnt0;
  logic       Gnt1;
  logic [7:0] ID;
  logic       IValid;
  logic       GntId;
  logic       Busy;
  logic       TimeoutErr;

  modport master (
    output Req0, Req1, D0, D1, V0, V1, L0, L1,
    input  Gnt0, Gnt1, ID, IValid, GntId, Busy, TimeoutErr
  );

  modport slave (
    input  Req0, Req1, D0, D1, V0, V1, L0, L1,
    output Gnt0, Gnt1, ID, IValid, GntId, Busy, TimeoutErr
  );
endinterface

// File: rtl/stc0_ingress_arb.sv
// Round-robin whole-frame arbiter feeding stc0_core ingress (ID/IValid).
// STC0_ARB_TIMEOUT_EN enables mid-frame stall abort after TIMEOUT_CYCLES.
module stc0_ingress_arb #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic              Clk,
  input logic              ARstb,
  stc0_ingress_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_e;

  localparam logic [15:0] GAP_LAST =
    16'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic GAP_EN = (GAP_CYCLES > 0);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        gid_q, gid_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic [7:0]  id_q, id_d;
  logic        ivalid_q, ivalid_d;
  logic        busy_q, busy_d;
  logic        terr_q, terr_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;

  logic        sel;
  logic        v_sel;
  logic        l_sel;
  logic [7:0]  d_sel;
  logic        end_frame;

`ifdef STC0_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q, to_cnt_d;
`endif

  assign v_sel = gid_q ? bus.V1 : bus.V0;
  assign l_sel = gid_q ? bus.L1 : bus.L0;
  assign d_sel = gid_q ? bus.D1 : bus.D0;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    gnt0_d    = gnt0_q;
    gnt1_d    = gnt1_q;
    id_d      = id_q;
    ivalid_d  = 1'b0;
    terr_d    = 1'b0;
    gap_cnt_d = gap_cnt_q;
    sel       = 1'b0;
    end_frame = 1'b0;
`ifdef STC0_ARB_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.Req0 | bus.Req1) begin
          // Pointer only breaks ties; a lone requester always wins.
          sel     = (bus.Req0 & bus.Req1) ? ptr_q : bus.Req1;
          gid_d   = sel;
          gnt0_d  = ~sel;
          gnt1_d  = sel;
          state_d = S_GRANT;
`ifdef STC0_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      S_GRANT: begin
        if (v_sel) begin
          id_d     = d_sel;
          ivalid_d = 1'b1;
          if (l_sel) end_frame = 1'b1;
        end
`ifdef STC0_ARB_TIMEOUT_EN
        if (v_sel) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          end_frame = 1'b1;
          terr_d    = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`endif
        if (end_frame) begin
          gnt0_d    = 1'b0;
          gnt1_d    = 1'b0;
          ptr_d     = ~gid_q;
          gap_cnt_d = '0;
          state_d   = GAP_EN ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or negedge ARstb) begin
    if (!ARstb) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      gid_q     <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      id_q      <= 8'h00;
      ivalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
      gap_cnt_q <= '0;
`ifdef STC0_ARB_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      id_q      <= id_d;
      ivalid_q  <= ivalid_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
      gap_cnt_q <= gap_cnt_d;
`ifdef STC0_ARB_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  assign bus.Gnt0       = gnt0_q;
  assign bus.Gnt1       = gnt1_q;
  assign bus.GntId      = gid_q;
  assign bus.ID         = id_q;
  assign bus.IValid     = ivalid_q;
  assign bus.Busy       = busy_q;
  assign bus.TimeoutErr = terr_q;

endmodule

// File: tb/tb_stc0_ingress_arb.sv
// Bench for stc0_ingress_arb: vector table, byte scoreboard, reset and
// stall-abort sequences (expectations follow STC0_ARB_TIMEOUT_EN).
module tb_stc0_ingress_arb;

  logic Clk = 1'b0;
  logic ARstb = 1'b0;
  int compared = 0;
  int mismatched = 0;
  logic [7:0] sbq[$];
  bit mon_en = 1'b0;

  stc0_ingress_arb_if bus ();

  stc0_ingress_arb #(
    .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .Clk(Clk),
    .ARstb(ARstb),
    .bus(bus.slave)
  );

  always #5 Clk = ~Clk;

  // {g0,g1,gid,ivalid,busy,terr,id}
  wire [13:0] obs = {bus.Gnt0, bus.Gnt1, bus.GntId, bus.IValid,
                     bus.Busy, bus.TimeoutErr, bus.ID};

  typedef struct {
    logic [5:0]  ctl;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic [5:0] c, input logic [7:0] a,
                              input logic [7:0] b, input logic [13:0] e);
    vec_t v;
    v.ctl = c;
    v.d0 = a;
    v.d1 = b;
    v.exp = e;
    return v;
  endfunction

  function automatic logic [13:0] ex(input logic [4:0] f,
                                     input logic [7:0] id);
    return {f, 1'b0, id};
  endfunction

  // ctl = {Req0,Req1,V0,L0,V1,L1}
  task automatic drive(input logic [5:0] c, input logic [7:0] a,
                       input logic [7:0] b);
    {bus.Req0, bus.Req1, bus.V0, bus.L0, bus.V1, bus.L1} = c;
    bus.D0 = a;
    bus.D1 = b;
  endtask

  task automatic chk(input string nm, input logic [13:0] act,
                     input logic [13:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (mon_en) begin
      compared++;
      if (bus.Gnt0 && bus.Gnt1) begin
        mismatched++;
        $display("FAIL gnt_excl: got both grants high want at most one");
      end
      if (bus.IValid === 1'b1) begin
        compared++;
        if (sbq.size() == 0) begin
          mismatched++;
          $display("FAIL sb_extra: got ID %h want no beat", bus.ID);
        end else begin
          logic [7:0] e;
          e = sbq.pop_front();
          if (bus.ID !== e) begin
            mismatched++;
            $display("FAIL sb_data: got %h want %h", bus.ID, e);
          end
        end
      end
    end
  end

  logic [2:0] texp[1:7];
  logic g0e, g1e;

  initial begin
    tbl[0]  = mk(6'b110000, 8'h00, 8'h00, ex(5'b10001, 8'h00));
    tbl[1]  = mk(6'b111010, 8'hA1, 8'hFF, ex(5'b10011, 8'hA1));
    tbl[2]  = mk(6'b111000, 8'hA2, 8'h00, ex(5'b10011, 8'hA2));
    tbl[3]  = mk(6'b111111, 8'hA3, 8'hFF, ex(5'b00011, 8'hA3));
    tbl[4]  = mk(6'b110000, 8'h00, 8'h00, ex(5'b00001, 8'hA3));
    tbl[5]  = mk(6'b110000, 8'h00, 8'h00, ex(5'b00000, 8'hA3));
    tbl[6]  = mk(6'b110000, 8'h00, 8'h00, ex(5'b01101, 8'hA3));
    tbl[7]  = mk(6'b111111, 8'hEE, 8'hB1, ex(5'b00111, 8'hB1));
    tbl[8]  = mk(6'b100000, 8'h00, 8'h00, ex(5'b00101, 8'hB1));
    tbl[9]  = mk(6'b100000, 8'h00, 8'h00, ex(5'b00100, 8'hB1));
    tbl[10] = mk(6'b100000, 8'h00, 8'h00, ex(5'b10001, 8'hB1));
    tbl[11] = mk(6'b001000, 8'hC1, 8'h00, ex(5'b10011, 8'hC1));
    tbl[12] = mk(6'b000000, 8'h00, 8'h00, ex(5'b10001, 8'hC1));
    tbl[13] = mk(6'b001100, 8'hC2, 8'h00, ex(5'b00011, 8'hC2));
    tbl[14] = mk(6'b000000, 8'h00, 8'h00, ex(5'b00001, 8'hC2));
    tbl[15] = mk(6'b000000, 8'h00, 8'h00, ex(5'b00000, 8'hC2));
    tbl[16] = mk(6'b010000, 8'h00, 8'h00, ex(5'b01101, 8'hC2));
    tbl[17] = mk(6'b000011, 8'h00, 8'hD1, ex(5'b00111, 8'hD1));
    tbl[18] = mk(6'b000000, 8'h00, 8'h00, ex(5'b00101, 8'hD1));
    tbl[19] = mk(6'b000000, 8'h00, 8'h00, ex(5'b00100, 8'hD1));
    tbl[20] = mk(6'b100000, 8'h00, 8'h00, ex(5'b10001, 8'hD1));
    tbl[21] = mk(6'b001100, 8'hF1, 8'h00, ex(5'b00011, 8'hF1));
    tbl[22] = mk(6'b000000, 8'h00, 8'h00, ex(5'b00001, 8'hF1));
    tbl[23] = mk(6'b000000, 8'h00, 8'h00, ex(5'b00000, 8'hF1));

`ifdef STC0_ARB_TIMEOUT_EN
    texp[1] = 3'b100; texp[2] = 3'b100; texp[3] = 3'b100;
    texp[4] = 3'b001; texp[5] = 3'b000; texp[6] = 3'b000;
    texp[7] = 3'b010;
`else
    for (int k = 1; k <= 7; k++) texp[k] = 3'b100;
`endif

    drive(6'b000000, 8'h00, 8'h00);
    #12;
    chk("rst_state", obs, 14'h0);
    @(negedge Clk);
    ARstb = 1'b1;
    mon_en = 1'b1;

    g0e = 1'b0;
    g1e = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].ctl, tbl[i].d0, tbl[i].d1);
      if (tbl[i].ctl[3] && g0e) sbq.push_back(tbl[i].d0);
      if (tbl[i].ctl[1] && g1e) sbq.push_back(tbl[i].d1);
      @(negedge Clk);
      chk($sformatf("vec%0d", i), obs, tbl[i].exp);
      g0e = tbl[i].exp[13];
      g1e = tbl[i].exp[12];
    end

    // Pointer is 1 here; interrupted frame on requester 1.
    drive(6'b010000, 8'h00, 8'h00);
    @(negedge Clk);
    chk("rst_pre_gnt", {11'h0, obs[13:11]}, 14'h3);
    drive(6'b010010, 8'h00, 8'hE1);
    sbq.push_back(8'hE1);
    @(negedge Clk);
    drive(6'b010010, 8'h00, 8'hE2);
    sbq.push_back(8'hE2);
    @(negedge Clk);
    drive(6'b010010, 8'h00, 8'hE3);
    #2 ARstb = 1'b0;
    #1 chk("rst_mid", obs, 14'h0);
    @(negedge Clk);
    drive(6'b010011, 8'h00, 8'hE4);
    @(negedge Clk);
    chk("rst_hold", obs, 14'h0);
    drive(6'b000000, 8'h00, 8'h00);
    #2 ARstb = 1'b1;
    @(negedge Clk);
    chk("rst_quiet", obs, 14'h0);
    drive(6'b110000, 8'h00, 8'h00);
    @(negedge Clk);
    chk("rst_ptr", {11'h0, obs[13:11]}, 14'h4);

    // One beat then a stall with requester 1 waiting.
    drive(6'b111000, 8'h61, 8'h00);
    sbq.push_back(8'h61);
    @(negedge Clk);
    for (int k = 1; k <= 7; k++) begin
      drive(6'b110000, 8'h00, 8'h00);
      @(negedge Clk);
      chk($sformatf("to_k%0d", k), {11'h0, obs[13], obs[12], obs[8]},
          {11'h0, texp[k]});
    end

    drive(6'b000000, 8'h00, 8'h00);
    repeat (2) @(negedge Clk);
    chk("sb_drain", 14'(sbq.size()), 14'h0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stc0_ingress_arb.md
# stc0_ingress_arb

Two-requester frame arbiter that shares the single byte-wide ingress port (ID/IValid) of stc0_core between two byte-stream sources, e.g. the pad-side stream and an on-chip LFSR test-pattern source. Grants whole frames round-robin, enforces an inter-frame idle gap, and registers the selected stream onto the core's ingress bus. Sits directly in front of stc0_core in the user project wrapper and runs in the ingress clock domain.

## Interface
Parameters:
- GAP_CYCLES, 2, idle cycles inserted after each frame before the next grant (0 allowed)
- TIMEOUT_CYCLES, 64, consecutive no-valid cycles mid-frame before abort (used only with STC0_ARB_TIMEOUT_EN; min 1)

Ports:
- Clk  in  1  ingress clock; all logic rising-edge
- ARstb  in  1  reset, asynchronous, active-low
- Req0 / Req1  in  1  requester n has a frame pending
- D0 / D1  in  8  requester n data byte
- V0 / V1  in  1  requester n byte valid (sampled only while Gntn=1)
- L0 / L1  in  1  last byte of frame, qualified by Vn
- Gnt0 / Gnt1  out  1  grant to requester n; at most one high
- ID  out  8  data to stc0_core ingress
- IValid  out  1  ID valid to stc0_core
- GntId  out  1  index of current/last granted requester
- Busy  out  1  high in GRANT or GAP states
- TimeoutErr  out  1  one-cycle pulse on timeout abort (0 when feature compiled out)

## Operation
- States: IDLE, GRANT, GAP. Round-robin pointer Ptr (1 bit) names the preferred requester.
- IDLE: if only one Req high, grant it; if both, grant Ptr. Transition to GRANT registered: Gntn rises the cycle after Req is seen in IDLE. GntId updates with Gntn.
- GRANT: Gntn=1. Each cycle with Vn=1, Dn captured; Req changes ignored until frame ends. Vn=1 and Ln=1 ends frame: Gntn drops next cycle, Ptr set to other requester, go GAP (or IDLE if GAP_CYCLES=0).
- Ungranted requester's Vn/Ln/Dn ignored entirely.
- GAP: count GAP_CYCLES cycles with IValid=0, Gnt0=Gnt1=0, then IDLE.
- Output: ID/IValid registered; IValid=1 exactly for cycles following accepted beats; ID holds last value when IValid=0.
- No backpressure: core accepts every IValid beat; requesters must drive Vn only when ready.
- Reset (any time, including mid-frame): async clear to IDLE, Ptr=0, counters 0, all outputs 0 (Gnt0, Gnt1, ID=8'h00, IValid, GntId, Busy, TimeoutErr). Partial frame truncated; no recovery beat emitted.

## Timing
- Req to Gnt: 1 cycle from IDLE (Req sampled edge k, Gnt high after edge k+1).
- Beat latency: Vn sampled edge k → ID/IValid valid after edge k+1 (1 cycle).
- Back-to-back beats: full throughput, one byte per cycle.
- Last beat at edge k: Gntn low after edge k+1; earliest next Gnt after edge k+GAP_CYCLES+2.
- Same-cycle Req0 and Req1 in IDLE: Ptr wins; after its frame, other wins if still requesting.
- Req dropped before grant: no grant issued; Req dropped in GRANT: grant held until Last or timeout.
- Single-byte frame (Vn=Ln=1 first granted cycle) legal.

## Configuration
- STC0_ARB_TIMEOUT_EN defined: in GRANT a counter counts consecutive cycles with Vn=0, cleared on each valid beat. When it reaches TIMEOUT_CYCLES: TimeoutErr pulses 1 cycle, Gntn drops, Ptr flips, go GAP; no IValid emitted for the aborted tail.
- Undefined: no counter, grant held indefinitely until Ln; TimeoutErr tied 0.

## Test plan
- Reset: ARstb low mid-sim → all outputs 0, state IDLE; release, Req1=1 only → Gnt1 after 1 cycle, GntId=1.
- Single frame: Req0, bytes 8'hA1,8'hA2,8'hA3 (L0 on A3) → ID shows A1..A3 with IValid 3 consecutive cycles, 1-cycle latency; Gnt0 drops after A3; 2 idle cycles before any new Gnt.
- Contention: Req0=Req1=1 from reset → frame from 0 first, then frame from 1, then 0; Gnt0 and Gnt1 never both high.
- Ignored traffic: requester 1 toggles V1/D1=8'hFF while requester 0 granted → no 8'hFF on ID.
- Reset mid-frame: ARstb low after 2 of 4 bytes → IValid=0 immediately, Ptr=0, no further bytes.
- Timeout (with STC0_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): grant 0, one byte, then V0=0 for 4 cycles → TimeoutErr single pulse, Gnt0 low, next grant to requester 1; without macro same stimulus → Gnt0 held, TimeoutErr stays 0.
